// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } adder_op_t;

  // Control half of a stage record; the WIDTH-dependent partial result and
  // pending operand bits travel alongside it as parameterized buses.
  typedef struct packed {
    logic      valid;
    adder_op_t op;
    logic      smode;
    logic      carry;
  } stage_ctl_t;

  function automatic logic calc_overflow(input logic c_msb, input logic co,
                                         input adder_op_t op, input logic smode);
    if (smode) return c_msb ^ co;
    return (op == OP_SUB) ? ~co : co;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One W-bit slice of the carry-chained adder with its hold-able register bank.
module adder_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int W     = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  stage_ctl_t       d_ctl,
  input  logic [WIDTH-1:0] d_a,
  input  logic [WIDTH-1:0] d_b,
  input  logic [WIDTH-1:0] d_r,
  output stage_ctl_t       q_ctl,
  output logic [WIDTH-1:0] q_a,
  output logic [WIDTH-1:0] q_b,
  output logic [WIDTH-1:0] q_r
);

  logic [W:0]       sum;
  logic [WIDTH-1:0] r_nxt;

  assign sum = {1'b0, d_a[IDX*W +: W]} + {1'b0, d_b[IDX*W +: W]} + {{W{1'b0}}, d_ctl.carry};

  // Lower slices arrive already finished; this stage fills in its own slice.
  always_comb begin
    r_nxt = d_r;
    r_nxt[IDX*W +: W] = sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_ctl <= '0;
      q_a   <= '0;
      q_b   <= '0;
      q_r   <= '0;
    end else if (en) begin
      q_ctl.valid <= d_ctl.valid;
      q_ctl.op    <= d_ctl.op;
      q_ctl.smode <= d_ctl.smode;
      q_ctl.carry <= sum[W];
      q_a         <= d_a;
      q_b         <= d_b;
      q_r         <= r_nxt;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Parametrised pipelined add/sub: STAGES carry-chained slices, valid/ready
// handshake with full back-pressure (whole pipe holds while output stalls).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             op_sub,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sout,
  output logic             cout,
  output logic             overflow
);

  localparam int W = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: illegal WIDTH/STAGES combination");
  end

  stage_ctl_t [STAGES:0]            ctl;
  logic       [STAGES:0][WIDTH-1:0] a_p, b_p, r_p;
  logic       [STAGES:0]            vld_pipe;
  logic                             stall;
  logic                             c_msb;
  logic                             unused_pend;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Subtraction is A + ~B + ~borrow, so both inversions happen at entry.
  assign ctl[0].valid = in_valid;
  assign ctl[0].op    = op_sub ? OP_SUB : OP_ADD;
  assign ctl[0].smode = signed_mode;
  assign ctl[0].carry = op_sub ^ cin;
  assign a_p[0]       = in1;
  assign b_p[0]       = op_sub ? ~in2 : in2;
  assign r_p[0]       = '0;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    adder_stage #(.WIDTH(WIDTH), .W(W), .IDX(i)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (~stall),
      .d_ctl (ctl[i]),
      .d_a   (a_p[i]),
      .d_b   (b_p[i]),
      .d_r   (r_p[i]),
      .q_ctl (ctl[i+1]),
      .q_a   (a_p[i+1]),
      .q_b   (b_p[i+1]),
      .q_r   (r_p[i+1])
    );
  end

  for (genvar i = 0; i <= STAGES; i++) begin : g_vld
    assign vld_pipe[i] = ctl[i].valid;
  end

  // Carry into the MSB recovered from sum ^ a ^ b' at that bit.
  assign c_msb = r_p[STAGES][WIDTH-1] ^ a_p[STAGES][WIDTH-1] ^ b_p[STAGES][WIDTH-1];

  assign out_valid = vld_pipe[STAGES];
  assign sout      = r_p[STAGES];
  assign cout      = ctl[STAGES].carry;
  assign overflow  = calc_overflow(c_msb, ctl[STAGES].carry, ctl[STAGES].op, ctl[STAGES].smode);

  assign unused_pend = ^{a_p[STAGES][WIDTH-2:0], b_p[STAGES][WIDTH-2:0]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: arithmetic model + scoreboard,
// directed literal vectors, streaming, back-pressure and mid-flight reset.
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic              clk = 1'b0;
  logic              rst_n, in_valid, in_ready, cin, op_sub, signed_mode;
  logic              out_valid, out_ready, cout, overflow;
  logic [WIDTH-1:0]  in1, in2, sout;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   pop_cyc[$];

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .cin         (cin),
    .op_sub      (op_sub),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sout        (sout),
    .cout        (cout),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: plain wide integer arithmetic, overflow judged by range.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic sub, input logic sm);
    longint ua, ub, sa, sb, ci, r, rs, smax, smin;
    exp_t e;
    ua = a; ub = b; ci = c;
    sa = $signed(a); sb = $signed(b);
    smax = 2147483647;
    smin = -smax - 1;
    if (sub) begin
      r  = ua - ub - ci;
      rs = sa - sb - ci;
      e.c = (r >= 0);
    end else begin
      r  = ua + ub + ci;
      rs = sa + sb + ci;
      e.c = (r > 64'sd4294967295);
    end
    e.s = r[31:0];
    if (sm) e.o = (rs > smax) || (rs < smin);
    else    e.o = sub ? (r < 0) : e.c;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) q.delete();
    else if (in_valid && in_ready) q.push_back(model(in1, in2, cin, op_sub, signed_mode));
  end

  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_beat: got sout %0h with no beat outstanding (t=%0t)", sout, $time);
      end else begin
        chk("sb_sout", 64'(sout), 64'(q[0].s));
        chk("sb_cout", 64'(cout), 64'(q[0].c));
        chk("sb_ovf",  64'(overflow), 64'(q[0].o));
        if (out_ready) begin
          void'(q.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s, input logic m);
    in_valid = 1'b1; in1 = a; in2 = b; cin = c; op_sub = s; signed_mode = m;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk); #2;
  endtask

  task automatic single(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic s, input logic m,
                        input logic [31:0] es, input logic ec, input logic eo);
    int n = 0;
    bit got = 0;
    @(posedge clk); #2;
    drive(a, b, c, s, m);
    @(posedge clk); #2;
    in_valid = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) got = 1;
    end
    chk({nm, "_lat"},  64'(n), 64'(STAGES));
    chk({nm, "_sout"}, 64'(sout), 64'(es));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    chk({nm, "_ovf"},  64'(overflow), 64'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic [31:0] cap_s;
    logic        cap_c, cap_o;
    int          acc, n0, spur;

    sa = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
           32'h7FFF_FFFF, 32'h0000_0000, 32'hDEAD_BEEF, 32'h4000_0000};
    sb = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8765_4321,
           32'hFFFF_FFFF, 32'h0000_0001, 32'h0123_4567, 32'h4000_0000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; cin = 1'b0; op_sub = 1'b0; signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sout",      64'(sout), 64'd0);
    chk("rst_cout",      64'(cout), 64'd0);
    chk("rst_ovf",       64'(overflow), 64'd0);
    chk("rst_in_ready",  64'(in_ready), 64'd1);

    single("uadd_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0000_0000, 1, 1);
    single("sadd_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 32'h8000_0000, 0, 1);
    single("uadd_nov",  32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h8000_0000, 0, 0);
    single("usub_brw",  32'd5, 32'd7, 0, 1, 0, 32'hFFFF_FFFE, 0, 1);
    single("ssub_neg",  32'd5, 32'd7, 0, 1, 1, 32'hFFFF_FFFE, 0, 0);
    single("sub_bin",   32'd10, 32'd3, 1, 1, 0, 32'd6, 1, 0);
    single("ssub_ovf",  32'h8000_0000, 32'h0000_0001, 0, 1, 1, 32'h7FFF_FFFF, 1, 1);
    single("sadd_neg",  32'h8000_0000, 32'h8000_0000, 0, 0, 1, 32'h0000_0000, 1, 1);
    single("uadd_cin",  32'h0000_00FF, 32'h0000_0000, 1, 0, 0, 32'h0000_0100, 0, 0);

    // Streaming: 8 back-to-back beats with mixed op/mode.
    @(posedge clk); #2;
    acc = cyc + 1;
    n0  = pop_cyc.size();
    for (int j = 0; j < 8; j++) begin
      drive(sa[j], sb[j], j[0], j[1], j[2]);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    wait_empty();
    chk("stream_cnt", 64'(pop_cyc.size() - n0), 64'd8);
    for (int j = 0; j < 8; j++)
      chk("stream_t", 64'((n0 + j < pop_cyc.size()) ? pop_cyc[n0 + j] : -1), 64'(acc + 3 + j));

    // Back-pressure: fill with 4 beats while output is blocked.
    n0 = pop_cyc.size();
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(32'd100 + 32'(j), 32'(j), 0, j[0], 0);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_first_valid", 64'(out_valid), 64'd1);
    cap_s = sout; cap_c = cout; cap_o = overflow;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid",    64'(out_valid), 64'd1);
      chk("bp_hold",     64'({cap_c, cap_o, cap_s}), 64'({cout, overflow, sout}));
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_empty();
    chk("bp_cnt", 64'(pop_cyc.size() - n0), 64'd4);
    for (int j = 1; j < 4; j++)
      chk("bp_back2back", 64'((n0 + j < pop_cyc.size()) ? pop_cyc[n0 + j] - pop_cyc[n0 + j - 1] : -1), 64'd1);

    // Reset with 3 beats in flight.
    for (int j = 0; j < 3; j++) begin
      drive(32'h1000 + 32'(j), 32'h1, 0, 0, 0);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_valid",    64'(out_valid), 64'd0);
    chk("mrst_sout",     64'(sout), 64'd0);
    chk("mrst_cout",     64'(cout), 64'd0);
    chk("mrst_ovf",      64'(overflow), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    spur = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spur++;
    end
    chk("mrst_no_stale", 64'(spur), 64'd0);
    single("post_rst", 32'h0000_1234, 32'h0000_0001, 1, 0, 0, 32'h0000_1236, 0, 0);
    wait_empty();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined adder/subtractor that supersedes the fixed 32-bit combinational unsigned adder in the arithmetic library. It splits a WIDTH-bit operation into STAGES equal carry-chained slices, with one register bank per slice. It supports unsigned/signed add and subtract with carry/borrow-in, and produces carry-out and mode-correct overflow. A valid/ready handshake with full back-pressure lets it sit directly in streaming datapaths.

## Interface
- WIDTH, 32, operand/result width in bits; ≥ 2.
- STAGES, 4, pipeline depth and slice count; 1 ≤ STAGES ≤ WIDTH; WIDTH % STAGES == 0 (elaboration error otherwise).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- op_sub  input  1  0 = A+B+cin; 1 = A−B−cin.
- signed_mode  input  1  0 = unsigned overflow rule; 1 = two's-complement rule.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sout  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB.
- overflow  output  1  result not representable in the selected mode.

## Operation
- Slice width W = WIDTH/STAGES. Stage i adds bits [i·W +: W] of A and B' with the carry registered from stage i−1.
- B' = op_sub ? ~in2 : in2. Carry into bit 0 = op_sub ? ~cin : cin.
- Unslice operand bits travel with the beat in delay registers. Completed low result slices are carried forward, so stage STAGES−1 holds the full result.
- cout = carry out of bit WIDTH−1. In sub mode, cout = 1 means no borrow.
- overflow:
  - unsigned add: cout.
  - unsigned sub: ~cout.
  - signed (add or sub): carry into MSB XOR carry out of MSB.
- op_sub and signed_mode are captured with the beat and travel with it. Mode changes between beats are legal.
- Handshake: a beat transfers when valid && ready on a rising edge.
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - While stall is high, every stage register and valid bit holds.
  - While stall is low, all stages advance one step. Empty slots (valid 0) propagate as bubbles.
- Outputs are stable while out_valid && !out_ready. No beat is dropped or duplicated.
- Reset (rst_n = 0 at an edge):
  - all stage valid bits clear; in-flight beats are discarded.
  - out_valid = 0, sout = 0, cout = 0, overflow = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset has priority over stall and over any transfer in the same cycle.

## Timing
- Latency: a beat accepted at edge k appears with out_valid = 1 after edge k+STAGES−1, i.e. STAGES cycles from acceptance to output presentation, when there is no stall.
- Throughput: one beat per cycle when out_ready is held high.
- Each stall cycle adds exactly one cycle of latency to every in-flight beat.
- in_ready depends combinationally on out_ready, so out_ready must not depend combinationally on in_ready.
- Simultaneous input accept and output accept in one cycle is legal and is the normal steady state.
- STAGES = 1: single register stage; latency 1; the behaviour is otherwise identical.

## Structure
- Package adder_pkg holds:
  - typedef adder_op_t {OP_ADD, OP_SUB}.
  - per-stage pipeline record struct: valid, mode bits, carry, partial result, pending operand bits.
  - function computing overflow from (carry into MSB, cout, op, signed_mode).
- Sub-module adder_stage: one W-bit slice adder plus its hold-able register bank, with an enable = !stall input. Instantiate it STAGES times in a generate loop.

## Test plan
- WIDTH=32, STAGES=4, unsigned add: 0xFFFFFFFF + 0x00000001, cin=0 → after 4 cycles, sout=0x00000000, cout=1, overflow=1.
- Signed add: 0x7FFFFFFF + 0x00000001 → sout=0x80000000, cout=0, overflow=1. Same operands with signed_mode=0 → overflow=0.
- Unsigned sub: 5 − 7, cin=0 → sout=0xFFFFFFFE, cout=0, overflow=1. Signed 5 − 7 → same sout, overflow=0. Sub 10 − 3 with borrow-in cin=1 → sout=6.
- Streaming: 8 back-to-back beats, mixed op/mode, out_ready=1 → 8 results in order on 8 consecutive cycles, first result 4 cycles after the first accept.
- Back-pressure: 4 beats accepted, then out_ready=0 for 3 cycles → in_ready=0 and outputs frozen during the stall. After release, all 4 results appear exactly once, in order.
- Reset mid-flight: rst_n=0 for one edge with 3 beats in flight → out_valid=0 and sout/cout/overflow=0 next cycle, no stale beats emerge, in_ready=1. A new beat then completes in 4 cycles.
